// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests, PC-tagged response FIFO, redirect flush.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [DW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0] tag_mem    [FIFO_DEPTH];

    logic redir, req_fire, rsp_push, rsp_drop, pop, credit_free;
    logic unused_target_lsbs;

    assign unused_target_lsbs = ^redirect_target[1:0];

    assign redir    = redirect && (state_q != StBoot);
    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = instr_valid && instr_ready;
    // A response seen in the redirect cycle belongs to the wrong path.
    assign rsp_drop = imem_rsp_valid && ((drop_q != '0) || redir);
    assign rsp_push = imem_rsp_valid && (drop_q == '0) && !redir;

    assign outstanding_d = redir ? '0 : outstanding_q + CW'(req_fire) - CW'(rsp_push);
    assign occ_d         = redir ? '0 : occ_q + CW'(rsp_push) - CW'(pop);
    assign drop_d        = drop_q + (redir ? DW'(outstanding_q) + DW'(req_fire) : '0)
                           - DW'(rsp_drop);
    assign rd_ptr_d      = redir ? '0 : rd_ptr_q + PW'(pop);
    assign wr_ptr_d      = redir ? '0 : wr_ptr_q + PW'(rsp_push);
    assign tag_rd_d      = redir ? '0 : tag_rd_q + PW'(rsp_push);
    assign tag_wr_d      = redir ? '0 : tag_wr_q + PW'(req_fire);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redir) begin
            fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    assign credit_free = ({1'b0, occ_d} + {1'b0, outstanding_d}) < (CW + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:           state_d = StFetch;
            StFetch, StStall: state_d = credit_free ? StFetch : StStall;
            default:          state_d = StBoot;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == StFetch);
        imem_req_addr  = fetch_pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            occ_q         <= '0;
            drop_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            occ_q         <= occ_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            fifo_instr[wr_ptr_q] <= imem_rsp_data;
            fifo_pc[wr_ptr_q]    <= tag_mem[tag_rd_q];
        end
        if (req_fire && !redir) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
    end

    assign instr_valid = (occ_q != '0);
    assign Instr       = instr_valid ? fifo_instr[rd_ptr_q] : '0;
    assign PC          = instr_valid ? fifo_pc[rd_ptr_q] : '0;
    assign PCPlus4     = instr_valid ? fifo_pc[rd_ptr_q] + XLEN'(4) : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] flushed_inc;
    logic [32:0] fetched_sum, flushed_sum;

    assign flushed_inc = (redir ? 32'(occ_q) - 32'(pop) : 32'd0) + 32'(rsp_drop);
    assign fetched_sum = {1'b0, perf_fetched} + 33'(pop);
    assign flushed_sum = {1'b0, perf_flushed} + {1'b0, flushed_inc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: in-order memory model, expected stream queue,
// independent monitor comparing the decode-side outputs and request credit/address.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid, instr_ready;
    logic [31:0] Instr, PC, PCPlus4;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .Instr           (Instr),
        .PC              (PC),
        .PCPlus4         (PCPlus4)
    );

    typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] addr; int cyc;} mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          since_rst = 0;
    int          accepts = 0;
    int          first_acc = -1;
    int          first_vld = -1;
    logic [31:0] model_pc = 32'h0;
    int          rdy_pct, irdy_pct, red_pct, rsp_pct;
    bit          force_red = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares decode-side outputs against the expected stream.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
            check("rst_instr", Instr, 32'd0);
            check("rst_pc", PC, 32'd0);
            check("rst_pcplus4", PCPlus4, 32'd0);
        end else begin
            check("req_valid_credit", {31'b0, imem_req_valid},
                  {31'b0, (since_rst >= 1) && (sb.size() < DEPTH)});
            if (instr_valid) begin
                if (sb.size() == 0) begin
                    check("instr_valid_unexpected", {31'b0, instr_valid}, 32'd0);
                end else begin
                    check("head_pc", PC, sb[0].pc);
                    check("head_instr", Instr, sb[0].data);
                    check("head_pcplus4", PCPlus4, sb[0].pc + 32'd4);
                    if (instr_ready) sb.delete(0);
                end
            end
        end
    end

    task automatic drive();
        imem_req_ready  = ($urandom_range(99) < rdy_pct);
        instr_ready     = ($urandom_range(99) < irdy_pct);
        redirect        = ($urandom_range(99) < red_pct);
        redirect_target = ($urandom_range(3) == 0) ? 32'($urandom_range(511)) : $urandom;
        if (force_red) begin
            redirect        = 1'b1;
            redirect_target = 32'hFFFF_FFF8;
        end
        if (mq.size() > 0 && mq[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Reference bookkeeping for the cycle whose inputs are now stable.
    task automatic book();
        bit red_eff;
        red_eff = redirect && (since_rst >= 1);
        if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
        if (instr_valid && first_vld < 0) first_vld = cyc;
        if (imem_rsp_valid && mq.size() > 0) mq.delete(0);
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, cyc: cyc});
            if (!red_eff) sb.push_back('{pc: model_pc, data: memf(model_pc)});
            model_pc = model_pc + 32'd4;
            accepts++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (red_eff) begin
            sb.delete();
            model_pc = {redirect_target[31:2], 2'b00};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        since_rst++;
        drive();
        @(negedge clk);
        #1;
        book();
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("async_rst_pc", PC, 32'd0);
        check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        repeat (3) @(posedge clk);
        sb.delete();
        mq.delete();
        model_pc  = 32'h0;
        accepts   = 0;
        first_acc = -1;
        first_vld = -1;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        since_rst = 0;
    endtask

    task automatic set_mix(input int rdy, input int irdy, input int red, input int rsp);
        rdy_pct  = rdy;
        irdy_pct = irdy;
        red_pct  = red;
        rsp_pct  = rsp;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Decode stalled: exactly DEPTH requests, first head two cycles after first accept.
        set_mix(100, 0, 0, 100);
        repeat (20) step();
        check("stall_accepts", 32'(accepts), 32'(DEPTH));
        check("first_latency", 32'(first_vld - first_acc), 32'd2);

        set_mix(100, 100, 0, 100);
        repeat (40) step();

        set_mix(70, 70, 4, 70);
        repeat (2500) step();

        // Retarget a pending request and exercise redirect with outstanding responses.
        set_mix(30, 50, 15, 40);
        repeat (1500) step();

        // Address wrap at the top of the address space.
        set_mix(100, 100, 0, 100);
        force_red = 1'b1;
        step();
        force_red = 1'b0;
        repeat (30) step();

        // Fill the FIFO, then reset asynchronously mid-stream.
        set_mix(100, 0, 0, 100);
        repeat (10) step();
        do_reset();
        set_mix(80, 80, 3, 80);
        repeat (1000) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
